// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, opcode/funct constants and datapath select codes
// for the multicycle MIPS control path.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ERROR   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory request and therefore wait on MemReady.
    function automatic logic is_mem_state(input state_t s);
        return s inside {S_FETCH, S_MEMRD, S_MEMWR};
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp and Funct to the ALU control code, flagging unsupported Funct values.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  alu_op_t    alu_op,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        if (alu_op == ALUOP_SUB)
            alu_control = ALU_SUB;
        else if (alu_op == ALUOP_FUNCT)
            case (funct)
                FN_ADD:  alu_control = ALU_ADD;
                FN_SUB:  alu_control = ALU_SUB;
                FN_AND:  alu_control = ALU_AND;
                FN_OR:   alu_control = ALU_OR;
                FN_SLT:  alu_control = ALU_SLT;
                default: illegal = 1'b1;
            endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main sequencer of the multicycle MIPS datapath, with memory
// ready handshake, wait timeout and a sticky error trap.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter bit USE_READY   = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       c_IorD,
    output logic       c_MemRead,
    output logic       c_MemWrite,
    output logic       c_IRWrite,
    output logic       c_PCEn,
    output logic       c_RegWrite,
    output logic       c_RegDst,
    output logic       c_MemToReg,
    output logic       c_ALUSrcA,
    output logic [1:0] c_ALUSrcB,
    output logic [2:0] c_ALUControl,
    output logic [1:0] c_PCSrc,
    output logic       Error,
    output logic [3:0] State
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        state, state_n;
    logic [CW-1:0] wait_cnt, wait_cnt_n;
    logic          ready, mem_state, timed_out;
    logic          pc_write, branch, alu_en, alu_illegal;
    alu_op_t       alu_op;
    logic [2:0]    dec_alu;

    assign ready     = USE_READY ? MemReady : 1'b1;
    assign mem_state = is_mem_state(state);
    // The cycle that would be the MEM_TIMEOUT-th unanswered one traps instead.
    assign timed_out = mem_state && !ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));
    assign alu_op    = (state == S_EXECUTE) ? ALUOP_FUNCT :
                       (state == S_BRANCH)  ? ALUOP_SUB   : ALUOP_ADD;

    alu_decoder u_alu_dec (
        .funct       (Funct),
        .alu_op      (alu_op),
        .alu_control (dec_alu),
        .illegal     (alu_illegal)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        c_IorD     = 1'b0;
        c_MemRead  = 1'b0;
        c_MemWrite = 1'b0;
        c_IRWrite  = 1'b0;
        c_RegWrite = 1'b0;
        c_RegDst   = 1'b0;
        c_MemToReg = 1'b0;
        c_ALUSrcA  = 1'b0;
        c_ALUSrcB  = SRCB_B;
        c_PCSrc    = PCSRC_ALU;
        alu_en     = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            S_FETCH: begin
                c_MemRead = 1'b1;
                c_ALUSrcB = SRCB_FOUR;
                alu_en    = 1'b1;
                c_IRWrite = ready;
                pc_write  = ready;
                state_n   = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c_ALUSrcB = SRCB_IMM_SH;
                alu_en    = 1'b1;
                state_n   = (Opcode == OP_LW || Opcode == OP_SW) ? S_MEMADR  :
                            (Opcode == OP_RTYPE)                 ? S_EXECUTE :
                            (Opcode == OP_BEQ)                   ? S_BRANCH  :
                            (Opcode == OP_ADDI)                  ? S_ADDIEX  :
                            (Opcode == OP_J)                     ? S_JUMP    : S_ERROR;
            end
            S_MEMADR: begin
                c_ALUSrcA = 1'b1;
                c_ALUSrcB = SRCB_IMM;
                alu_en    = 1'b1;
                state_n   = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c_IorD    = 1'b1;
                c_MemRead = 1'b1;
                state_n   = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                c_MemToReg = 1'b1;
                c_RegWrite = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEMWR: begin
                c_IorD     = 1'b1;
                c_MemWrite = 1'b1;
                state_n    = ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                c_ALUSrcA = 1'b1;
                alu_en    = 1'b1;
                state_n   = alu_illegal ? S_ERROR : S_ALUWB;
            end
            S_ALUWB: begin
                c_RegDst   = 1'b1;
                c_RegWrite = 1'b1;
                state_n    = S_FETCH;
            end
            S_BRANCH: begin
                c_ALUSrcA = 1'b1;
                alu_en    = 1'b1;
                c_PCSrc   = PCSRC_ALUOUT;
                branch    = 1'b1;
                state_n   = S_FETCH;
            end
            S_ADDIEX: begin
                c_ALUSrcA = 1'b1;
                c_ALUSrcB = SRCB_IMM;
                alu_en    = 1'b1;
                state_n   = S_ADDIWB;
            end
            S_ADDIWB: begin
                c_RegWrite = 1'b1;
                state_n    = S_FETCH;
            end
            S_JUMP: begin
                c_PCSrc  = PCSRC_JUMP;
                pc_write = 1'b1;
                state_n  = S_FETCH;
            end
            default: state_n = S_ERROR;
        endcase
        if (timed_out)
            state_n = S_ERROR;
    end

    assign wait_cnt_n   = (state_n != state)      ? '0 :
                          (mem_state && !ready)   ? wait_cnt + CW'(1) : wait_cnt;
    assign c_ALUControl = alu_en ? dec_alu : 3'b000;
    assign c_PCEn       = pc_write | (branch & Zero);
    assign Error        = (state == S_ERROR);
    assign State        = state;

endmodule
